// File: rtl/rv32i_types.sv
// Shared RV32I load/store encodings and data-memory FSM state for the MEM stage.
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} dmem_state_t;

  function automatic logic is_load(input logic [2:0] f3);
    return f3 inside {3'(lb), 3'(lh), 3'(lw), 3'(lbu), 3'(lhu)};
  endfunction

  function automatic logic is_store(input logic [2:0] f3);
    return f3 inside {3'(sb), 3'(sh), 3'(sw)};
  endfunction

  // Low two funct3 bits encode access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b10 && off != 2'b00) || (f3[1:0] == 2'b01 && off[0]);
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half lane out of a read word and sign/zero-extends it.
module load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[8*offset +: 8];
  assign half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    word = rdata;
    case (funct3)
      3'(lb):  word = {{24{byte_lane[7]}}, byte_lane};
      3'(lbu): word = {24'h0, byte_lane};
      3'(lh):  word = {{16{half_lane[15]}}, half_lane};
      3'(lhu): word = {16'h0, half_lane};
      default: word = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-cache interface: request strobes, lane steering, load formatting and stall control.
module dmem_access_unit
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  input  logic        advance,
  output logic        data_mem_read,
  output logic        data_mem_write,
  output logic [31:0] data_mem_address,
  output logic [3:0]  data_mbe,
  output logic [31:0] data_mem_wdata,
  input  logic        data_mem_resp,
  input  logic [31:0] data_mem_rdata,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  dmem_state_t state, state_nxt;
  logic [1:0]  off;
  logic        bad, pending, resp_cycle, load_resp;
  logic [31:0] fmt, load_q;

  assign off = alu_out[1:0];

  always_comb begin
    bad = 1'b0;
    if (mem_read && mem_write) bad = 1'b1;
    else if (mem_read)         bad = !is_load(funct3)  || misaligned(funct3, off);
    else if (mem_write)        bad = !is_store(funct3) || misaligned(funct3, off);
  end

  assign mem_err    = !rst && ex_mem_valid && bad;
  assign pending    = !rst && ex_mem_valid && (mem_read ^ mem_write) && !mem_err &&
                      (state != DONE);
  assign resp_cycle = pending && data_mem_resp;
  assign load_resp  = resp_cycle && mem_read;

  assign data_mem_read    = pending && mem_read;
  assign data_mem_write   = pending && mem_write;
  assign mem_stall        = pending && !data_mem_resp;
  assign data_mem_address = {alu_out[31:2], 2'b00};
  assign data_mem_wdata   = rs2_data << {off, 3'b000};

  always_comb begin
    data_mbe = 4'hF;
    if (!mem_read) begin
      case (funct3[1:0])
        2'b00:   data_mbe = 4'b0001 << off;
        2'b01:   data_mbe = 4'b0011 << off;
        default: data_mbe = 4'hF;
      endcase
    end
  end

  load_align u_align (
    .rdata  (data_mem_rdata),
    .offset (off),
    .funct3 (funct3),
    .word   (fmt)
  );

  assign load_data = load_resp ? fmt : load_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCESS: begin
        if (!pending)          state_nxt = IDLE;
        else if (data_mem_resp) state_nxt = advance ? IDLE : DONE;
        else                   state_nxt = ACCESS;
      end
      DONE:    if (advance) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      load_q       <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (load_resp) load_q <= fmt;
      if (mem_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a load-result scoreboard.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid, mem_read, mem_write, advance;
  logic [2:0]  funct3;
  logic [31:0] alu_out, rs2_data;
  logic        data_mem_read, data_mem_write;
  logic [31:0] data_mem_address;
  logic [3:0]  data_mbe;
  logic [31:0] data_mem_wdata;
  logic        data_mem_resp;
  logic [31:0] data_mem_rdata;
  logic [31:0] load_data;
  logic        mem_stall, mem_err;
  logic [31:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_access_unit dut (
    .clk              (clk),
    .rst              (rst),
    .ex_mem_valid     (ex_mem_valid),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .funct3           (funct3),
    .alu_out          (alu_out),
    .rs2_data         (rs2_data),
    .advance          (advance),
    .data_mem_read    (data_mem_read),
    .data_mem_write   (data_mem_write),
    .data_mem_address (data_mem_address),
    .data_mbe         (data_mbe),
    .data_mem_wdata   (data_mem_wdata),
    .data_mem_resp    (data_mem_resp),
    .data_mem_rdata   (data_mem_rdata),
    .load_data        (load_data),
    .mem_stall        (mem_stall),
    .mem_err          (mem_err),
    .stall_cycles     (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare load_data against the oldest outstanding expected load result.
  task automatic chk_load(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s scoreboard empty observed=%h expected=none", tag, load_data);
    end else begin
      e = exp_q.pop_front();
      chk(tag, load_data, e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    ex_mem_valid = v; mem_read = rd; mem_write = wr; funct3 = f3; alu_out = a; rs2_data = d;
  endtask

  initial begin
    rst = 1'b1; advance = 1'b0; data_mem_resp = 1'b0; data_mem_rdata = '0;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    // Reset forces strobes/stall/err low even with a live load present
    sample();
    chk("rst_read", {31'b0, data_mem_read}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_err", {31'b0, mem_err}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    sample();
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    next_cycle();
    rst = 1'b0;

    // SB at 0x1003, response after 3 stall cycles
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h1003, 32'h0000_00AB);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("sb_stall", {31'b0, mem_stall}, 32'd1);
      chk("sb_write", {31'b0, data_mem_write}, 32'd1);
      next_cycle();
    end
    data_mem_resp = 1'b1; advance = 1'b1;
    sample();
    chk("sb_mbe", {28'b0, data_mbe}, 32'b1000);
    chk("sb_wdata", data_mem_wdata, 32'hAB00_0000);
    chk("sb_addr", data_mem_address, 32'h1000);
    chk("sb_resp_stall", {31'b0, mem_stall}, 32'd0);
    chk("sb_resp_write", {31'b0, data_mem_write}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0); data_mem_resp = 1'b0;
    sample();
    chk("sb_stall_cycles", stall_cycles, 32'd3);
    next_cycle();

    // LB offset 2, zero-wait response
    drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h2002, 32'h0);
    data_mem_resp = 1'b1; data_mem_rdata = 32'h0080_FF00; advance = 1'b1;
    exp_q.push_back(32'hFFFF_FF80);
    sample();
    chk("lb_stall", {31'b0, mem_stall}, 32'd0);
    chk("lb_read", {31'b0, data_mem_read}, 32'd1);
    chk("lb_mbe", {28'b0, data_mbe}, 32'hF);
    chk_load("lb_load_data");
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0); data_mem_resp = 1'b0;
    data_mem_rdata = 32'h1111_1111;
    sample();
    chk("lb_hold", load_data, 32'hFFFF_FF80);
    chk("lb_stall_cycles", stall_cycles, 32'd3);
    next_cycle();

    // LHU offset 2, response while the pipeline is frozen (advance=0)
    drive(1'b1, 1'b1, 1'b0, 3'b101, 32'h3002, 32'h0); advance = 1'b0;
    sample();
    chk("lhu_stall", {31'b0, mem_stall}, 32'd1);
    next_cycle();
    data_mem_resp = 1'b1; data_mem_rdata = 32'h8001_0000;
    exp_q.push_back(32'h0000_8001);
    sample();
    chk_load("lhu_load_data");
    chk("lhu_resp_stall", {31'b0, mem_stall}, 32'd0);
    next_cycle();
    data_mem_resp = 1'b0; data_mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("done_no_rereq", {31'b0, data_mem_read}, 32'd0);
      chk("done_no_stall", {31'b0, mem_stall}, 32'd0);
      chk("done_hold", load_data, 32'h0000_8001);
      next_cycle();
    end
    advance = 1'b1;
    sample();
    chk("done_adv_hold", load_data, 32'h0000_8001);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    sample();
    chk("lhu_stall_cycles", stall_cycles, 32'd4);
    next_cycle();

    // Misaligned / illegal accesses
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h1002, 32'h0);
    sample();
    chk("lw_mis_err", {31'b0, mem_err}, 32'd1);
    chk("lw_mis_read", {31'b0, data_mem_read}, 32'd0);
    chk("lw_mis_stall", {31'b0, mem_stall}, 32'd0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h1000, 32'h0);
    sample();
    chk("f3_011_err", {31'b0, mem_err}, 32'd1);
    chk("f3_011_read", {31'b0, data_mem_read}, 32'd0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h1001, 32'h0);
    sample();
    chk("sh_mis_err", {31'b0, mem_err}, 32'd1);
    chk("sh_mis_write", {31'b0, data_mem_write}, 32'd0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h1000, 32'h0);
    sample();
    chk("rw_both_err", {31'b0, mem_err}, 32'd1);
    chk("rw_both_stall", {31'b0, mem_stall}, 32'd0);
    next_cycle();

    // SH offset 2, zero-wait
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h6002, 32'h0000_BEEF);
    data_mem_resp = 1'b1; data_mem_rdata = 32'h0;
    sample();
    chk("sh_mbe", {28'b0, data_mbe}, 32'b1100);
    chk("sh_wdata", data_mem_wdata, 32'hBEEF_0000);
    chk("sh_err", {31'b0, mem_err}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0); data_mem_resp = 1'b0;
    next_cycle();

    // Reset in the middle of an outstanding LW
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h4000, 32'h0);
    sample();
    chk("lw_pre_rst_stall", {31'b0, mem_stall}, 32'd1);
    next_cycle();
    rst = 1'b1;
    sample();
    chk("mid_rst_read", {31'b0, data_mem_read}, 32'd0);
    chk("mid_rst_stall", {31'b0, mem_stall}, 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h4000, 32'h0);
    data_mem_resp = 1'b1; data_mem_rdata = 32'hDEAD_BEEF;
    sample();
    chk("post_rst_stall_cycles", stall_cycles, 32'd0);
    chk("late_resp_load_data", load_data, 32'd0);
    chk("late_resp_read", {31'b0, data_mem_read}, 32'd0);
    next_cycle();
    data_mem_resp = 1'b0;
    sample();
    chk("late_resp_hold", load_data, 32'd0);
    next_cycle();

    // Normal LW after reset, one wait cycle
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h5000, 32'h0); advance = 1'b1;
    sample();
    chk("lw_stall", {31'b0, mem_stall}, 32'd1);
    next_cycle();
    data_mem_resp = 1'b1; data_mem_rdata = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    sample();
    chk_load("lw_load_data");
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0); data_mem_resp = 1'b0;
    sample();
    chk("lw_stall_cycles", stall_cycles, 32'd1);
    chk("lw_hold", load_data, 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 Parameters: none; data and address widths are fixed at 32 bits (rv32i).
REQ-002 clk  in  1  single clock; every state element updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 ex_mem_valid  in  1  EX/MEM register holds a live instruction.
REQ-005 mem_read, mem_write  in  1 each  load / store control from EX/MEM register.
REQ-006 funct3  in  3  RV32I load/store width code.
REQ-007 alu_out  in  32  effective byte address.
REQ-008 rs2_data  in  32  store data, unshifted.
REQ-009 advance  in  1  the EX/MEM register loads new content at the next edge.
REQ-010 data_mem_read, data_mem_write  out  1 each  request strobes to data cache.
REQ-011 data_mem_address  out  32  word-aligned address: alu_out with bits [1:0] forced to 0.
REQ-012 data_mbe  out  4  byte enables.
REQ-013 data_mem_wdata  out  32  lane-shifted store data.
REQ-014 data_mem_resp  in  1  cache completion, single-cycle pulse.
REQ-015 data_mem_rdata  in  32  read data, valid with data_mem_resp.
REQ-016 load_data  out  32  formatted load result for MEM/WB.
REQ-017 mem_stall  out  1  freeze the pipeline.
REQ-018 mem_err  out  1  misaligned or illegal access flag.
REQ-019 stall_cycles  out  32  saturating count of cycles with mem_stall=1.

Function
REQ-020 An access is pending when ex_mem_valid=1, exactly one of mem_read/mem_write is 1, mem_err=0, and state is IDLE or ACCESS.
REQ-021 FSM states: IDLE, ACCESS, DONE.
REQ-022 IDLE->ACCESS: access pending and data_mem_resp=0.
REQ-023 IDLE or ACCESS, data_mem_resp=1 with advance=1 -> IDLE; with advance=0 -> DONE.
REQ-024 DONE->IDLE when advance=1; otherwise DONE holds.
REQ-025 Request strobes are asserted combinationally while an access is pending, and held until data_mem_resp; they are never asserted in DONE.
REQ-026 mem_stall = access pending AND data_mem_resp=0; a zero-wait response in the first cycle causes no stall.
REQ-027 Misaligned accesses: word with alu_out[1:0]!=0; half with alu_out[0]=1.
REQ-028 Illegal accesses: funct3 not a defined load/store code; mem_read and mem_write both 1.
REQ-029 A misaligned or illegal access with ex_mem_valid=1 sets mem_err=1 (combinational) and issues no request and no stall.
REQ-030 Store byte enables, with off=alu_out[1:0]: SB = 0001<<off; SH = 0011<<off; SW = 1111.
REQ-031 Store data: data_mem_wdata = rs2_data<<(8*off).
REQ-032 Loads drive data_mbe=1111.
REQ-033 Load formatting: LB/LH sign-extend and LBU/LHU zero-extend the selected lane; LW passes the word through.
REQ-034 In the response cycle, load_data is formatted combinationally from data_mem_rdata.
REQ-035 In the response cycle the formatted value is also registered; in DONE, load_data is driven from that register.
REQ-036 Outside the response cycle and DONE, load_data holds the last registered value.
REQ-037 stall_cycles increments by 1 on each cycle with mem_stall=1 and saturates at 0xFFFFFFFF.

Reset
REQ-038 When rst=1 at an edge: state=IDLE, load register=0, stall_cycles=0.
REQ-039 While rst=1: strobes, mem_stall and mem_err are forced to 0, including a reset received in ACCESS mid-request.
REQ-040 A data_mem_resp arriving after reset is ignored unless a new access is pending.

Structure
REQ-041 Package rv32i_types holds: load_funct3_t (lb, lh, lw, lbu, lhu), store_funct3_t (sb, sh, sw), dmem_state_t.
REQ-042 Load formatting is a combinational sub-module named load_align (inputs rdata, offset, funct3; output formatted word).

Verification
REQ-043 SB, alu_out=0x1003, rs2=0x000000AB, resp after 3 cycles -> mbe=1000, wdata=0xAB000000, address=0x1000, mem_stall=1 for 3 cycles, stall_cycles=3.
REQ-044 LB, offset 2, rdata=0x0080FF00, zero-wait resp -> load_data=0xFFFFFF80, mem_stall never 1.
REQ-045 LHU, offset 2, rdata=0x8001_0000, resp with advance=0 for 2 cycles -> DONE, no re-request, load_data=0x00008001 held until advance.
REQ-046 LW at 0x1002 -> mem_err=1, no strobes, no stall; funct3=3'b011 load -> mem_err=1.
REQ-047 rst asserted in ACCESS -> strobes 0 in the rst cycle, state IDLE, stall_cycles=0; a late resp does not change load_data.
